// File: rtl/mult_share_arbiter.sv
// Two-requester front end for one shared sequential multiplier.
// Round-robin grant, one-shot start, watchdog on completion, and a held
// response channel back to whichever requester was granted.
module mult_share_arbiter #(
  parameter int WIDTH   = 64,
  parameter int RES_W   = 2*WIDTH+1,
  parameter int TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [RES_W-1:0] rsp_data,
  output logic             rsp_err,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  output logic             mul_start,
  input  logic             mul_ready,
  input  logic [RES_W-1:0] mul_result
);

  localparam int CW = $clog2(TIMEOUT+1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_SETTLE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic              rr_ptr;   // requester favoured when both are valid
  logic              gnt;      // requester owning the current transaction
  logic              gnt_sel;
  logic [CW-1:0]     wd_cnt;
  logic              wd_hit;
  logic              rsp_acc;
  logic [1:0][WIDTH-1:0] op_a, op_b;

  assign op_a = {req_a1, req_a0};
  assign op_b = {req_b1, req_b0};

  // Pick the single valid requester, or the round-robin one on contention.
  always_comb begin
    gnt_sel = 1'b0;
    if (&req_valid) gnt_sel = rr_ptr;
    else            gnt_sel = req_valid[1];
  end

  assign wd_hit  = (wd_cnt == CW'(TIMEOUT-1));
  assign rsp_acc = (state_q == S_RESP) && rsp_ready[gnt];

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state and handshake strobes; everything here is decoded from state.
  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    mul_start = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          req_ready[gnt_sel] = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mul_start = 1'b1;
        state_d   = S_SETTLE;
      end
      // The multiplier's busy flag lags start by a cycle, so ignore ready here.
      S_SETTLE: state_d = S_WAIT;
      S_WAIT: begin
        if (mul_ready || wd_hit) state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid[gnt] = 1'b1;
        if (rsp_acc) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand latch, watchdog, result capture and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr   <= 1'b0;
      gnt      <= 1'b0;
      mul_a    <= '0;
      mul_b    <= '0;
      wd_cnt   <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (|req_valid) begin
            gnt   <= gnt_sel;
            mul_a <= op_a[gnt_sel];
            mul_b <= op_b[gnt_sel];
          end
        end
        S_SETTLE: wd_cnt <= '0;
        S_WAIT: begin
          wd_cnt <= wd_cnt + CW'(1);
          // A completion on the timeout cycle still wins.
          if (mul_ready) begin
            rsp_data <= mul_result;
            rsp_err  <= 1'b0;
          end else if (wd_hit) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_acc) rr_ptr <= ~gnt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a behavioural multiplier model
// and an expected-response queue filled at grant time.
module tb_mult_share_arbiter;

  localparam int W   = 64;
  localparam int RW  = 2*W+1;
  localparam int TO  = 200;
  localparam int HANG = 1000000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    req_valid = 2'b00;
  logic [1:0]    req_ready;
  logic [W-1:0]  req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_ready = 2'b00;
  logic [RW-1:0] rsp_data;
  logic          rsp_err;
  logic [W-1:0]  mul_a, mul_b;
  logic          mul_start;
  logic          mul_ready;
  logic [RW-1:0] mul_result;

  mult_share_arbiter #(.WIDTH(W), .RES_W(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
    .mul_ready(mul_ready), .mul_result(mul_result)
  );

  always #5 clk = ~clk;

  // Multiplier model: busy for 'lat' cycles after start, product taken at start.
  int            lat = 1;
  logic          busy;
  int            rem;
  logic [RW-1:0] prod;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0; rem <= 0; prod <= '0;
    end else if (mul_start) begin
      busy <= 1'b1; rem <= lat;
      prod <= RW'(mul_a) * RW'(mul_b);
    end else if (busy) begin
      if (rem <= 1) busy <= 1'b0;
      else          rem  <= rem - 1;
    end
  end
  assign mul_ready  = ~busy;
  assign mul_result = prod;

  int n_cmp = 0;
  int n_bad = 0;
  int n_start = 0;

  always @(posedge clk) if (!reset && mul_start) n_start++;

  typedef struct {
    int            id;
    logic [W-1:0]  a, b;
    logic [RW-1:0] data;
    logic          err;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Handshake invariants checked every cycle outside reset.
  always @(negedge clk) begin
    if (!reset) begin
      chk("inv_req_ready_onehot0", RW'($onehot0(req_ready)), RW'(1'b1));
      chk("inv_rsp_valid_onehot0", RW'($onehot0(rsp_valid)), RW'(1'b1));
      chk("inv_ready_vs_valid", RW'((|req_ready) && (|rsp_valid)), RW'(1'b0));
    end
  end

  function automatic logic [1:0] oh(input int id);
    return (id == 1) ? 2'b10 : 2'b01;
  endfunction

  // Wait for a grant, check who got it, and queue the expected response.
  task automatic wait_grant(input int id);
    int   k;
    exp_t e;
    k = 0;
    #1;
    while (req_ready == 2'b00 && k < 50) begin
      @(negedge clk); #1; k++;
    end
    chk("grant", RW'(req_ready), RW'(oh(id)));
    e.id  = id;
    e.a   = (id == 1) ? req_a1 : req_a0;
    e.b   = (id == 1) ? req_b1 : req_b0;
    e.err = (lat > TO);
    e.data = e.err ? '0 : RW'(e.a) * RW'(e.b);
    sb.push_back(e);
    n_start = 0;
    @(posedge clk);
    @(negedge clk); #1;
    chk("req_ready_pulse", RW'(req_ready), RW'(2'b00));
  endtask

  // Wait for a response, compare against the queue head, optionally stall it.
  task automatic wait_rsp(input int hold);
    int   k;
    exp_t e;
    k = 0;
    while (rsp_valid == 2'b00 && k < TO + 40) begin
      @(negedge clk); #1; k++;
    end
    n_cmp++;
    assert (sb.size() != 0) else begin
      n_bad++;
      $error("FAIL sb_empty: observed 0 entries expected 1");
    end
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk("rsp_valid", RW'(rsp_valid), RW'(oh(e.id)));
    chk("rsp_data", rsp_data, e.data);
    chk("rsp_err", RW'(rsp_err), RW'(e.err));
    chk("mul_a_hold", RW'(mul_a), RW'(e.a));
    chk("mul_b_hold", RW'(mul_b), RW'(e.b));
    chk("start_pulses", RW'(n_start), RW'(1));
    for (int i = 0; i < hold; i++) begin
      rsp_ready = ~oh(e.id);
      @(negedge clk); #1;
      chk("bp_rsp_valid", RW'(rsp_valid), RW'(oh(e.id)));
      chk("bp_rsp_data", rsp_data, e.data);
      chk("bp_req_ready", RW'(req_ready), RW'(2'b00));
    end
    rsp_ready = oh(e.id);
    @(negedge clk);
    rsp_ready = 2'b00;
    #1;
    chk("rsp_drop", RW'(rsp_valid), RW'(2'b00));
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", RW'(req_ready), RW'(2'b00));
    chk("rst_rsp_valid", RW'(rsp_valid), RW'(2'b00));
    chk("rst_mul_start", RW'(mul_start), RW'(1'b0));
    chk("rst_mul_a", RW'(mul_a), RW'(0));
    chk("rst_rsp_data", rsp_data, RW'(0));
    chk("rst_rsp_err", RW'(rsp_err), RW'(1'b0));
    reset = 1'b0;

    // Contention: both held valid, grants alternate 0,1,0
    @(negedge clk);
    req_a0 = 64'hFFFF_FFFF_FFFF_FFFF; req_b0 = 64'd2;
    req_a1 = 64'd7;                   req_b1 = 64'd9;
    req_valid = 2'b11;
    wait_grant(0); wait_rsp(0);
    wait_grant(1); wait_rsp(0);
    wait_grant(0); wait_rsp(0);
    req_valid = 2'b00;

    // Single request 3*5
    @(negedge clk);
    req_a0 = 64'd3; req_b0 = 64'd5; req_valid = 2'b01;
    wait_grant(0);
    req_valid = 2'b00;
    wait_rsp(0);

    // Backpressure on r1 while r0 waits
    @(negedge clk);
    req_a1 = 64'd100; req_b1 = 64'd200; req_valid = 2'b10;
    wait_grant(1);
    req_a0 = 64'd11; req_b0 = 64'd13; req_valid = 2'b01;
    lat = 5;
    wait_rsp(10);
    wait_grant(0);
    req_valid = 2'b00;
    wait_rsp(0);

    // Watchdog timeout
    @(negedge clk);
    lat = HANG;
    req_a1 = 64'd5; req_b1 = 64'd6; req_valid = 2'b10;
    wait_grant(1);
    req_valid = 2'b00;
    wait_rsp(0);

    // Zero operands
    @(negedge clk);
    lat = 1;
    req_a0 = 64'd0; req_b0 = 64'd0; req_valid = 2'b01;
    wait_grant(0);
    req_valid = 2'b00;
    wait_rsp(0);

    // Ready lands exactly on the last watchdog cycle: product wins
    @(negedge clk);
    lat = TO;
    req_a1 = 64'd123; req_b1 = 64'd456; req_valid = 2'b10;
    wait_grant(1);
    req_valid = 2'b00;
    wait_rsp(0);

    // One cycle later: timeout wins
    @(negedge clk);
    lat = TO + 1;
    req_a0 = 64'd17; req_b0 = 64'd19; req_valid = 2'b01;
    wait_grant(0);
    req_valid = 2'b00;
    wait_rsp(0);

    // Async reset in WAIT (rr_ptr is 1 going in)
    @(negedge clk);
    lat = HANG;
    req_a1 = 64'd9; req_b1 = 64'd9; req_valid = 2'b10;
    wait_grant(1);
    req_valid = 2'b00;
    repeat (20) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_rsp_valid", RW'(rsp_valid), RW'(2'b00));
    chk("mid_rst_mul_a", RW'(mul_a), RW'(0));
    chk("mid_rst_mul_b", RW'(mul_b), RW'(0));
    chk("mid_rst_rsp_data", rsp_data, RW'(0));
    chk("mid_rst_mul_start", RW'(mul_start), RW'(1'b0));
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    lat = 1;
    req_a0 = 64'd2; req_b0 = 64'd2;
    req_a1 = 64'd3; req_b1 = 64'd3;
    req_valid = 2'b11;
    wait_grant(0);
    req_valid = 2'b10;
    wait_rsp(0);
    wait_grant(1);
    req_valid = 2'b00;
    wait_rsp(0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
